// File: rtl/fpc_accumulator_pkg.sv
// fpc_accumulator_pkg: shared state encoding and count-width helper
package fpc_accumulator_pkg;
  typedef logic [0:0] state_t;
  localparam state_t ACC  = 1'b0;
  localparam state_t DONE = 1'b1;
  function automatic int cnt_width(input int l);
    return $clog2(l + 1);
  endfunction
endpackage

// File: rtl/fpc_accumulator_control.sv
// fpc_accumulator_control: group FSM and product counter, drives datapath enables
module fpc_accumulator_control import fpc_accumulator_pkg::*; #(
  parameter int len = 8,
  localparam int CW = cnt_width(len)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          recv_val,
  input  logic          recv_last,
  input  logic          send_rdy,
  output logic          recv_rdy,
  output logic          send_val,
  output logic          acc_en,
  output logic          acc_clr,
  output logic          sum_load,
  output logic [CW-1:0] cnt
);
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic xfer, grp_end;
  always_comb begin
    xfer     = recv_val & (state_q == ACC);
    grp_end  = xfer & (recv_last | (cnt_q == CW'(len - 1)));
    acc_en   = xfer & ~grp_end;
    acc_clr  = grp_end;
    sum_load = grp_end;
    cnt_d    = grp_end ? '0 : xfer ? cnt_q + CW'(1) : cnt_q;
    state_d  = (state_q == ACC) ? (grp_end ? DONE : ACC) : (send_rdy ? ACC : DONE);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ACC;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end
  assign recv_rdy = (state_q == ACC);
  assign send_val = (state_q == DONE);
  assign cnt      = cnt_q;
endmodule

// File: rtl/fpc_accumulator.sv
// fpc_accumulator: sums groups of up to len complex products, presents each sum on val/rdy
module fpc_accumulator import fpc_accumulator_pkg::*; #(
  parameter int n   = 32,
  parameter int d   = 16,
  parameter int len = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       recv_val,
  output logic                       recv_rdy,
  input  logic [n-1:0]               recv_r,
  input  logic [n-1:0]               recv_c,
  input  logic                       recv_last,
  output logic                       send_val,
  input  logic                       send_rdy,
  output logic [n-1:0]               sum_r,
  output logic [n-1:0]               sum_c,
  output logic [cnt_width(len)-1:0]  sum_cnt
);
  localparam int CW = cnt_width(len);
  if (len < 1 || d < 0 || d > n) begin : g_bad_cfg
    $error("fpc_accumulator: invalid len or d");
  end
  logic acc_en, acc_clr, sum_load;
  logic [CW-1:0] cnt;
  logic [n-1:0] acc_r_q, acc_r_d, acc_c_q, acc_c_d, sum_r_q, sum_r_d, sum_c_q, sum_c_d;
  logic [CW-1:0] sum_cnt_q, sum_cnt_d;
  fpc_accumulator_control #(.len(len)) u_ctrl (
    .clk(clk), .reset(reset), .recv_val(recv_val), .recv_last(recv_last),
    .send_rdy(send_rdy), .recv_rdy(recv_rdy), .send_val(send_val),
    .acc_en(acc_en), .acc_clr(acc_clr), .sum_load(sum_load), .cnt(cnt)
  );
  // modular n-bit adds: wrap on overflow to match the multiplier output format
  always_comb begin
    acc_r_d   = acc_clr ? '0 : acc_en ? acc_r_q + recv_r : acc_r_q;
    acc_c_d   = acc_clr ? '0 : acc_en ? acc_c_q + recv_c : acc_c_q;
    sum_r_d   = sum_load ? acc_r_q + recv_r : sum_r_q;
    sum_c_d   = sum_load ? acc_c_q + recv_c : sum_c_q;
    sum_cnt_d = sum_load ? cnt + CW'(1) : sum_cnt_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      acc_r_q   <= '0;
      acc_c_q   <= '0;
      sum_r_q   <= '0;
      sum_c_q   <= '0;
      sum_cnt_q <= '0;
    end else begin
      acc_r_q   <= acc_r_d;
      acc_c_q   <= acc_c_d;
      sum_r_q   <= sum_r_d;
      sum_c_q   <= sum_c_d;
      sum_cnt_q <= sum_cnt_d;
    end
  end
  assign sum_r   = sum_r_q;
  assign sum_c   = sum_c_q;
  assign sum_cnt = sum_cnt_q;
endmodule
